// File: rtl/trie_lookup_scheduler.sv
// Trie lookup scheduler: request FIFO, credit-gated issue into a
// fixed-latency trie pipeline, tag delay line and in-order result FIFO.
module trie_lookup_scheduler #(
  parameter int PIPE_LATENCY = 9,
  parameter int REQ_DEPTH = 8,
  parameter int RES_DEPTH = 16,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_ip,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      trie_ip,
  input  logic [7:0]       trie_nexthop,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_nexthop,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy,
  output logic [15:0]      done_cnt
);
  localparam int QA = $clog2(REQ_DEPTH);
  localparam int RA = $clog2(RES_DEPTH);
  localparam int FW = $clog2(PIPE_LATENCY + 1);

  logic [31:0]      q_ip  [REQ_DEPTH];
  logic [TAG_W-1:0] q_tag [REQ_DEPTH];
  logic [QA-1:0]    q_wp;
  logic [QA-1:0]    q_rp;
  logic [QA:0]      q_cnt;

  logic [7:0]       r_nh  [RES_DEPTH];
  logic [TAG_W-1:0] r_tag [RES_DEPTH];
  logic [RA-1:0]    r_wp;
  logic [RA-1:0]    r_rp;
  logic [RA:0]      r_cnt;

  logic [PIPE_LATENCY-1:0] dl_v;
  logic [TAG_W-1:0]        dl_tag [PIPE_LATENCY];
  logic [FW-1:0]           inflight;

  logic        push;
  logic        issue;
  logic        cap;
  logic        pop;
  logic [31:0] used;

  // Every slot in the result FIFO is reserved at issue time, so a
  // capture always finds room.
  assign used      = 32'(inflight) + 32'(r_cnt);
  assign req_ready = (q_cnt != (QA+1)'(REQ_DEPTH));
  assign push      = req_valid && req_ready;
  assign issue     = (q_cnt != '0) && (used < 32'(RES_DEPTH));
  assign cap       = dl_v[PIPE_LATENCY-1];
  assign res_valid = (r_cnt != '0);
  assign pop       = res_valid && res_ready;

  assign res_nexthop = r_nh[r_rp];
  assign res_tag     = r_tag[r_rp];
  assign busy = (q_cnt != '0) || (r_cnt != '0) || (inflight != '0);

  // Storage arrays and tag delay line carry no reset; validity lives
  // in the counters and dl_v.
  always_ff @(posedge clk) begin
    if (push) begin
      q_ip[q_wp]  <= req_ip;
      q_tag[q_wp] <= req_tag;
    end
    if (cap) begin
      r_nh[r_wp]  <= trie_nexthop;
      r_tag[r_wp] <= dl_tag[PIPE_LATENCY-1];
    end
    dl_tag[0] <= q_tag[q_rp];
    for (int i = 1; i < PIPE_LATENCY; i++) begin
      dl_tag[i] <= dl_tag[i-1];
    end
  end

  // Request FIFO pointers, issue register and trie address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_wp    <= '0;
      q_rp    <= '0;
      q_cnt   <= '0;
      trie_ip <= '0;
    end else begin
      if (push) q_wp <= q_wp + QA'(1);
      if (issue) begin
        q_rp    <= q_rp + QA'(1);
        trie_ip <= q_ip[q_rp];
      end
      q_cnt <= q_cnt + (QA+1)'(push) - (QA+1)'(issue);
    end
  end

  // Valid delay line tracking lookups inside the trie, plus inflight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_v     <= '0;
      inflight <= '0;
    end else begin
      dl_v     <= {dl_v[PIPE_LATENCY-2:0], issue};
      inflight <= inflight + FW'(issue) - FW'(cap);
    end
  end

  // Result FIFO pointers and completed-lookup counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      done_cnt <= '0;
    end else begin
      if (cap) r_wp <= r_wp + RA'(1);
      if (pop) begin
        r_rp     <= r_rp + RA'(1);
        done_cnt <= done_cnt + 16'd1;
      end
      r_cnt <= r_cnt + (RA+1)'(cap) - (RA+1)'(pop);
    end
  end

endmodule

// File: tb/tb_trie_lookup_scheduler.sv
// Bench for trie_lookup_scheduler: fixed-latency trie model and an
// in-order request/result reference queue.
module tb_trie_lookup_scheduler;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_ip = '0;
  logic [TW-1:0] req_tag = '0;
  logic [31:0]   trie_ip;
  logic [7:0]    trie_nexthop;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [7:0]    res_nexthop;
  logic [TW-1:0] res_tag;
  logic          busy;
  logic [15:0]   done_cnt;

  int n_checks = 0;
  int n_pass = 0;
  int model_done = 0;
  logic [31:0]   exp_ip [$];
  logic [TW-1:0] exp_tag [$];
  logic [7:0]    tst [8];

  trie_lookup_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ip(req_ip), .req_tag(req_tag),
    .trie_ip(trie_ip), .trie_nexthop(trie_nexthop),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_nexthop(res_nexthop), .res_tag(res_tag),
    .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] nh_of(input logic [31:0] ip);
    return (ip[31:24] + ip[15:8]) ^ ip[7:0] ^ {ip[19:16], ip[23:20]};
  endfunction

  // Trie model: 8 stride registers behind trie_ip, never reset.
  assign trie_nexthop = tst[7];
  always @(posedge clk) begin
    tst[0] <= nh_of(trie_ip);
    for (int i = 1; i < 8; i++) tst[i] <= tst[i-1];
  end

  // Reference: results must match accepted requests in order.
  always @(negedge clk) begin
    if (rst) begin
      n_checks++;
      if (done_cnt !== 16'(model_done))
        $display("FAIL done_cnt got %0d want %0d", done_cnt, 16'(model_done));
      else n_pass++;
      if (res_valid && res_ready) begin
        n_checks++;
        if (exp_ip.size() == 0) begin
          $display("FAIL stale_result got tag %0h want none", res_tag);
        end else begin
          logic [31:0] ip;
          logic [TW-1:0] tg;
          ip = exp_ip.pop_front();
          tg = exp_tag.pop_front();
          if ({res_nexthop, res_tag} !== {nh_of(ip), tg})
            $display("FAIL result got nh %0h tag %0h want nh %0h tag %0h",
                     res_nexthop, res_tag, nh_of(ip), tg);
          else n_pass++;
        end
        model_done++;
      end
      if (req_valid && req_ready) begin
        exp_ip.push_back(req_ip);
        exp_tag.push_back(req_tag);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    n_checks++;
    if (got !== want)
      $display("FAIL %s got %0h want %0h", name, got, want);
    else n_pass++;
  endtask

  task automatic test_reset();
    #2;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done_cnt", 32'(done_cnt), 0);
    chk("rst_trie_ip", trie_ip, 0);
  endtask

  task automatic test_single();
    step();
    rst = 1'b1;
    req_valid = 1'b1;
    req_ip = 32'h0A000001;
    req_tag = 8'h05;
    step();
    req_valid = 1'b0;
    for (int e = 2; e <= 11; e++) begin
      step();
      if (e == 10) chk("single_early", 32'(res_valid), 0);
    end
    chk("single_valid", 32'(res_valid), 1);
    chk("single_tag", 32'(res_tag), 32'h05);
    chk("single_nh", 32'(res_nexthop), 32'(nh_of(32'h0A000001)));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("single_done", 32'(done_cnt), 1);
    chk("single_busy", 32'(busy), 0);
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int first = -1;
    int last = -1;
    int start = model_done;
    logic fire;
    res_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      req_valid = (sent < 20);
      req_ip = $urandom;
      req_tag = TW'(sent);
      if (res_valid) begin
        if (first < 0) first = c;
        last = c;
      end
      fire = req_valid && req_ready;
      step();
      if (fire) sent++;
    end
    req_valid = 1'b0;
    res_ready = 1'b0;
    chk("b2b_count", 32'(model_done - start), 20);
    chk("b2b_span", 32'(last - first), 19);
    chk("b2b_busy", 32'(busy), 0);
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int start = model_done;
    logic fire;
    res_ready = 1'b0;
    for (int c = 0; c < 60; c++) begin
      req_valid = (sent < 30);
      req_ip = $urandom;
      req_tag = TW'(8'h40 + sent);
      fire = req_valid && req_ready;
      step();
      if (fire) sent++;
    end
    chk("bp_accepted", 32'(sent), 24);
    chk("bp_req_ready", 32'(req_ready), 0);
    chk("bp_res_valid", 32'(res_valid), 1);
    chk("bp_busy", 32'(busy), 1);
    chk("bp_none_popped", 32'(model_done - start), 0);
    res_ready = 1'b1;
    for (int c = 0; c < 200 && (model_done - start) < 30; c++) begin
      req_valid = (sent < 30);
      req_ip = $urandom;
      req_tag = TW'(8'h40 + sent);
      fire = req_valid && req_ready;
      step();
      if (fire) sent++;
    end
    req_valid = 1'b0;
    res_ready = 1'b0;
    chk("bp_drained", 32'(model_done - start), 30);
    chk("bp_queue_empty", 32'(exp_ip.size()), 0);
    chk("bp_busy_end", 32'(busy), 0);
  endtask

  task automatic test_random();
    int sent = 0;
    int start = model_done;
    logic fire;
    for (int c = 0; c < 4000 && (model_done - start) < 150; c++) begin
      req_valid = (sent < 150) && ($urandom_range(0, 9) < 7);
      req_ip = $urandom;
      req_tag = TW'($urandom);
      res_ready = ($urandom_range(0, 9) < 6);
      fire = req_valid && req_ready;
      step();
      if (fire) sent++;
    end
    req_valid = 1'b0;
    res_ready = 1'b0;
    chk("rand_count", 32'(model_done - start), 150);
    chk("rand_queue_empty", 32'(exp_ip.size()), 0);
  endtask

  task automatic test_async_reset();
    int seen = 0;
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_ip = $urandom;
      req_tag = TW'(8'hA0 + i);
      step();
    end
    req_valid = 1'b0;
    step();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_req_ready", 32'(req_ready), 1);
    chk("ar_res_valid", 32'(res_valid), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_trie_ip", trie_ip, 0);
    chk("ar_done_cnt", 32'(done_cnt), 0);
    exp_ip.delete();
    exp_tag.delete();
    model_done = 0;
    step();
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (res_valid) seen++;
      step();
    end
    res_ready = 1'b0;
    chk("ar_no_stale", 32'(seen), 0);
  endtask

  task automatic test_done_wrap();
    int sent = 0;
    logic fire;
    step();
    rst = 1'b0;
    exp_ip.delete();
    exp_tag.delete();
    model_done = 0;
    step();
    rst = 1'b1;
    res_ready = 1'b1;
    for (int c = 0; c < 70000 && model_done < 65535; c++) begin
      req_valid = (sent < 65535);
      req_ip = $urandom;
      req_tag = TW'(sent);
      fire = req_valid && req_ready;
      step();
      if (fire) sent++;
    end
    req_valid = 1'b0;
    chk("wrap_pre", 32'(done_cnt), 32'hFFFF);
    req_valid = 1'b1;
    req_ip = $urandom;
    req_tag = 8'hEE;
    step();
    req_valid = 1'b0;
    for (int c = 0; c < 40 && model_done < 65536; c++) step();
    res_ready = 1'b0;
    chk("wrap_post", 32'(done_cnt), 0);
    chk("wrap_total", 32'(model_done), 65536);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_async_reset();
    test_done_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trie_lookup_scheduler.md
TRIE_LOOKUP_SCHEDULER -- requirements
Module: trie_lookup_scheduler

Interface
REQ-001 Parameter PIPE_LATENCY, default 9, is the edge count from trie_ip load to the matching trie_nexthop capture (8 stride stages + output register).
REQ-002 Parameter REQ_DEPTH, default 8, is the request FIFO depth (power of 2, >=2).
REQ-003 Parameter RES_DEPTH, default 16, is the result FIFO depth (power of 2, >= PIPE_LATENCY+1).
REQ-004 Parameter TAG_W, default 8, is the request tag width.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-low reset; rst=0 resets, rst=1 is normal operation.
REQ-007 Port req_valid, input, 1: a lookup request is present.
REQ-008 Port req_ready, output, 1: request FIFO not full.
REQ-009 Port req_ip, input, 32: destination IP to look up.
REQ-010 Port req_tag, input, TAG_W: opaque ID returned with the result.
REQ-011 Port trie_ip, output, 32: registered IP driven into the 4-bit-stride trie pipeline.
REQ-012 Port trie_nexthop, input, 8: trie pipeline result.
REQ-013 Port res_valid, output, 1: result FIFO not empty.
REQ-014 Port res_ready, input, 1: consumer accepts the result.
REQ-015 Port res_nexthop, output, 8: head-of-FIFO nexthop (first-word fall-through).
REQ-016 Port res_tag, output, TAG_W: head-of-FIFO tag.
REQ-017 Port busy, output, 1: high when either FIFO is non-empty or inflight != 0.
REQ-018 Port done_cnt, output, 16: count of results popped; wraps 0xFFFF->0.

Function
REQ-019 A request is accepted on an edge with req_valid && req_ready; {ip,tag} is written to the request FIFO tail.
REQ-020 No bypass: an accepted request is issued at the earliest on the following edge.
REQ-021 An issue occurs on an edge when the request FIFO is non-empty and inflight + res_count < RES_DEPTH (values before the edge); it pops the head, loads trie_ip <= ip, and shifts a 1 with the tag into the delay line.
REQ-022 At most one issue per edge; on non-issue edges a 0 enters the delay line and trie_ip holds its value.
REQ-023 The delay line is PIPE_LATENCY entries of {valid, tag}; on an edge where the tap entry is valid, {trie_nexthop, tag} is written to the result FIFO.
REQ-024 The credit rule guarantees capture never hits a full result FIFO; no result is ever dropped or reordered.
REQ-025 inflight increments on issue, decrements on capture, and is unchanged when both occur on one edge; range 0..PIPE_LATENCY.
REQ-026 A result is popped on an edge with res_valid && res_ready; pop and capture on one edge leave res_count unchanged; a pop frees its credit for the next edge.
REQ-027 Simultaneous request push and issue pop on a full request FIFO is not allowed: req_ready reflects pre-edge fullness only.
REQ-028 Minimum latency: accept at edge A -> issue at A+1 -> capture at A+1+PIPE_LATENCY -> res_valid high immediately after that edge.
REQ-029 Results leave in request order; throughput is one lookup per cycle while res_ready=1.

Reset
REQ-030 When rst=0, immediately and independently of clk: FIFOs empty, delay line all invalid, inflight=0, trie_ip=0, done_cnt=0, req_ready=1, res_valid=0, busy=0.
REQ-031 Reset mid-operation discards queued, in-flight and buffered lookups; trie outputs arriving later are ignored because their delay-line bits are cleared.
REQ-032 The first edge after rst rises may accept a request.

Verification
REQ-033 Single lookup, PIPE_LATENCY=9, trie model with fixed latency: ip 0x0A000001 tag 0x05 accepted at edge 1 -> res_valid after edge 11, res_tag=0x05, res_nexthop = model value; done_cnt=1 after pop.
REQ-034 Back-to-back: 20 requests, tags 0..19, res_ready=1 -> 20 results in tag order on 20 consecutive cycles; busy low after the last pop.
REQ-035 Backpressure: res_ready=0, 30 requests offered -> res_count peaks at 16, inflight+res_count never exceeds 16, req_ready drops after 8 more requests are queued; after release all 30 arrive in order.
REQ-036 Simultaneous capture and pop with a full result FIFO -> res_count stays 16 and no result is lost.
REQ-037 Async reset asserted between clock edges with 5 in flight -> all outputs reach reset values before the next edge; no stale result appears afterwards.
REQ-038 done_cnt preloaded near wrap by forcing 65535 pops -> the next pop gives 0.
